// File: rtl/cross_bar_rob_ctrl.sv
// Per-channel reorder controller for the four per-bank spw_buffers.
// Grants ROB numbers in order and tracks which bank services each entry.
// Once the head entry's write-back has landed, it is read from its bank
// and returned to the channel strictly in allocation order through a
// 2-deep output FIFO.
module cross_bar_rob_ctrl #(
  parameter int CHANNEL_ID = 0,
  parameter int DATA_W     = 128
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  alloc_valid_i,
  output logic                  alloc_ready_o,
  input  logic [1:0]            alloc_bank_i,
  output logic [2:0]            alloc_rob_num_o,
  input  logic [3:0]            bank_wr_valid_i,
  input  logic [11:0]           bank_wr_rob_num_i,
  output logic [3:0]            bank_rd_en_o,
  output logic [2:0]            bank_rd_ptr_o,
  input  logic [4*DATA_W-1:0]   bank_rd_data_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [DATA_W-1:0]     resp_data_o,
  output logic [2:0]            resp_rob_num_o,
  output logic                  err_o,
  output logic [1:0]            err_ch_o
);

  // Entry table and ring pointers
  logic [7:0]        ent_vld_q;
  logic [7:0]        ent_done_q;
  logic [1:0]        ent_bank_q [8];
  logic [2:0]        head_q, tail_q;
  logic [3:0]        count_q, count_d;

  // Outstanding bank read (1-cycle spw_buffer latency)
  logic              rd_pend_q;
  logic [1:0]        rd_bank_q;
  logic [2:0]        rd_rob_q;

  // Output FIFO
  logic [DATA_W-1:0] fifo_data_q [2];
  logic [2:0]        fifo_rob_q  [2];
  logic              fifo_wptr_q, fifo_rptr_q;
  logic [1:0]        fifo_cnt_q;

  logic              err_q;

  logic              alloc_fire;
  logic              pop;
  logic              push;
  logic              issue;
  logic [2:0]        occ;
  logic [2:0]        wr_rob [4];
  logic [3:0]        wr_ok;
  logic [DATA_W-1:0] rd_data_sel;

  assign alloc_ready_o   = ~count_q[3];
  assign alloc_rob_num_o = tail_q;
  assign alloc_fire      = alloc_valid_i & alloc_ready_o;

  assign resp_valid_o    = (fifo_cnt_q != 2'd0);
  assign resp_data_o     = resp_valid_o ? fifo_data_q[fifo_rptr_q] : '0;
  assign resp_rob_num_o  = resp_valid_o ? fifo_rob_q[fifo_rptr_q] : 3'd0;
  assign pop             = resp_valid_o & resp_ready_i;
  assign push            = rd_pend_q;

  assign err_o           = err_q;
  assign err_ch_o        = 2'(CHANNEL_ID);

  // Reads in flight plus buffered responses, net of this cycle's pop, must stay below 2
  assign occ   = 3'(fifo_cnt_q) + 3'(rd_pend_q) - 3'(pop);
  assign issue = ~rst_i & ent_vld_q[head_q] & ent_done_q[head_q] & (occ < 3'd2);

  assign bank_rd_en_o  = issue ? (4'b0001 << ent_bank_q[head_q]) : 4'b0000;
  assign bank_rd_ptr_o = head_q;

  assign count_d = count_q + 4'(alloc_fire) - 4'(issue);

  // Decode per-bank write-backs and validate them against the entry table
  always_comb begin
    for (int b = 0; b < 4; b++) begin
      wr_rob[b] = bank_wr_rob_num_i[3*b +: 3];
      wr_ok[b]  = ent_vld_q[wr_rob[b]] & ~ent_done_q[wr_rob[b]] &
                  (ent_bank_q[wr_rob[b]] == 2'(b));
    end
  end

  // Select the returning read data from the bank that was read last cycle
  always_comb begin
    rd_data_sel = '0;
    for (int b = 0; b < 4; b++) begin
      if (rd_bank_q == 2'(b)) rd_data_sel = bank_rd_data_i[b*DATA_W +: DATA_W];
    end
  end

  // Control state: entry flags, pointers, read tracking, FIFO occupancy, error
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ent_vld_q   <= '0;
      ent_done_q  <= '0;
      for (int i = 0; i < 8; i++) ent_bank_q[i] <= 2'd0;
      head_q      <= 3'd0;
      tail_q      <= 3'd0;
      count_q     <= 4'd0;
      rd_pend_q   <= 1'b0;
      fifo_wptr_q <= 1'b0;
      fifo_rptr_q <= 1'b0;
      fifo_cnt_q  <= 2'd0;
      err_q       <= 1'b0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (bank_wr_valid_i[b]) begin
          if (wr_ok[b]) ent_done_q[wr_rob[b]] <= 1'b1;
          else          err_q <= 1'b1;
        end
      end
      if (issue) begin
        ent_vld_q[head_q] <= 1'b0;
        head_q            <= head_q + 3'd1;
      end
      if (alloc_fire) begin
        ent_vld_q[tail_q]  <= 1'b1;
        ent_done_q[tail_q] <= 1'b0;
        ent_bank_q[tail_q] <= alloc_bank_i;
        tail_q             <= tail_q + 3'd1;
      end
      count_q   <= count_d;
      rd_pend_q <= issue;
      if (push) fifo_wptr_q <= ~fifo_wptr_q;
      if (pop)  fifo_rptr_q <= ~fifo_rptr_q;
      fifo_cnt_q <= fifo_cnt_q + 2'(push) - 2'(pop);
    end
  end

  // Datapath: capture read target and FIFO payload (no reset needed)
  always_ff @(posedge clk_i) begin
    if (issue) begin
      rd_bank_q <= ent_bank_q[head_q];
      rd_rob_q  <= head_q;
    end
    if (push) begin
      fifo_data_q[fifo_wptr_q] <= rd_data_sel;
      fifo_rob_q[fifo_wptr_q]  <= rd_rob_q;
    end
  end

endmodule

// File: tb/tb_cross_bar_rob_ctrl.sv
// Self-checking bench for cross_bar_rob_ctrl: behavioural spw_buffer banks,
// in-order scoreboard filled at allocation and drained on response handshakes.
module tb_cross_bar_rob_ctrl;
  localparam int DATA_W = 128;

  logic                clk = 1'b0;
  logic                rst;
  logic                alloc_valid;
  logic                alloc_ready;
  logic [1:0]          alloc_bank;
  logic [2:0]          alloc_rob;
  logic [3:0]          wr_v;
  logic [2:0]          wr_rob [4];
  logic [DATA_W-1:0]   wr_dat [4];
  logic [3:0]          rd_en;
  logic [2:0]          rd_ptr;
  logic [DATA_W-1:0]   rdd [4];
  logic                resp_valid;
  logic                resp_ready;
  logic [DATA_W-1:0]   resp_data;
  logic [2:0]          resp_rob;
  logic                err;
  logic [1:0]          err_ch;

  logic [DATA_W-1:0]   mem [4][8];
  logic [DATA_W-1:0]   data_of [8];
  int                  bank_of [8];

  typedef struct packed {
    logic [2:0]        rob;
    logic [DATA_W-1:0] data;
  } sb_t;
  sb_t sb [$];

  int checks = 0;
  int errors = 0;
  int tb_tail = 0;
  int rd_pulses = 0;
  bit sb_en = 1'b0;

  always #5 clk = ~clk;

  cross_bar_rob_ctrl #(.CHANNEL_ID(0), .DATA_W(DATA_W)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .alloc_valid_i    (alloc_valid),
    .alloc_ready_o    (alloc_ready),
    .alloc_bank_i     (alloc_bank),
    .alloc_rob_num_o  (alloc_rob),
    .bank_wr_valid_i  (wr_v),
    .bank_wr_rob_num_i({wr_rob[3], wr_rob[2], wr_rob[1], wr_rob[0]}),
    .bank_rd_en_o     (rd_en),
    .bank_rd_ptr_o    (rd_ptr),
    .bank_rd_data_i   ({rdd[3], rdd[2], rdd[1], rdd[0]}),
    .resp_valid_o     (resp_valid),
    .resp_ready_i     (resp_ready),
    .resp_data_o      (resp_data),
    .resp_rob_num_o   (resp_rob),
    .err_o            (err),
    .err_ch_o         (err_ch)
  );

  // spw_buffer models: write on wen, registered read on rd_en
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_v[b]) mem[b][wr_rob[b]] <= wr_dat[b];
      if (rd_en[b]) rdd[b] <= mem[b][rd_ptr];
    end
  end

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Response monitor / scoreboard
  always @(negedge clk) begin
    if (!rst && sb_en) begin
      if (rd_en != 4'd0) begin
        rd_pulses++;
        chk("rd_onehot", {127'd0, $onehot(rd_en)}, 1);
      end
      if (resp_valid && resp_ready) begin
        if (sb.size() == 0) begin
          chk("resp_unexpected", 1, 0);
        end else begin
          sb_t e;
          e = sb.pop_front();
          chk("resp_rob", resp_rob, e.rob);
          chk("resp_data", resp_data, e.data);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    sb_en = 1'b0;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    sb.delete();
    tb_tail = 0;
    rd_pulses = 0;
    sb_en = 1'b1;
  endtask

  task automatic do_alloc(input int b);
    sb_t e;
    alloc_valid = 1'b1;
    alloc_bank = 2'(b);
    @(negedge clk);
    chk("alloc_ready", alloc_ready, 1);
    chk("alloc_rob", alloc_rob, tb_tail);
    data_of[tb_tail] = {$urandom, $urandom, $urandom, $urandom};
    bank_of[tb_tail] = b;
    e.rob = 3'(tb_tail);
    e.data = data_of[tb_tail];
    sb.push_back(e);
    step();
    alloc_valid = 1'b0;
    tb_tail = (tb_tail + 1) % 8;
  endtask

  task automatic drv_wr_raw(input int b, input int r, input logic [DATA_W-1:0] d);
    wr_v[b] = 1'b1;
    wr_rob[b] = 3'(r);
    wr_dat[b] = d;
  endtask

  task automatic drv_wr(input int r);
    drv_wr_raw(bank_of[r], r, data_of[r]);
  endtask

  task automatic clr_wr();
    wr_v = 4'd0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    chk("drain_left", sb.size(), 0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; alloc_valid = 1'b0; alloc_bank = 2'd0; wr_v = 4'd0;
    resp_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin wr_rob[b] = 3'd0; wr_dat[b] = '0; rdd[b] = '0; end
    step();
    do_reset();

    // Reset state
    @(negedge clk);
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_alloc_rob", alloc_rob, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_ptr", rd_ptr, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_rob", resp_rob, 0);
    chk("rst_err", err, 0);
    chk("err_ch", err_ch, 0);
    step();

    // In-order delivery with out-of-order completion
    for (int i = 0; i < 3; i++) do_alloc(i);
    drv_wr(2);
    @(negedge clk); chk("t1_rd_en_a", rd_en, 0);
    step(); clr_wr(); drv_wr(0);
    @(negedge clk); chk("t1_rd_en_b", rd_en, 0);
    step(); clr_wr(); drv_wr(1);
    @(negedge clk); chk("t1_rd_en_0", rd_en, 4'b0001); chk("t1_ptr_0", rd_ptr, 0);
    step(); clr_wr();
    @(negedge clk); chk("t1_rd_en_1", rd_en, 4'b0010); chk("t1_ptr_1", rd_ptr, 1);
    step();
    @(negedge clk); chk("t1_rd_en_2", rd_en, 4'b0100); chk("t1_ptr_2", rd_ptr, 2);
    chk("t1_resp_valid", resp_valid, 1); chk("t1_resp_rob", resp_rob, 0);
    step();
    drain();

    // Full ROB, retire one, pointer wrap
    do_reset();
    for (int i = 0; i < 8; i++) do_alloc(i % 4);
    @(negedge clk); chk("full_ready", alloc_ready, 0);
    step();
    drv_wr(0);
    step(); clr_wr();
    @(negedge clk);
    chk("retire_rd_en", rd_en, 4'b0001 << bank_of[0]);
    chk("retire_no_bypass", alloc_ready, 0);
    step();
    @(negedge clk); chk("retire_ready", alloc_ready, 1);
    step();
    do_alloc(1);
    drv_wr(7); drv_wr(6); step(); clr_wr();
    for (int r = 5; r >= 1; r--) begin drv_wr(r); step(); clr_wr(); end
    drv_wr(0); step(); clr_wr();
    drain();
    for (int i = 0; i < 8; i++) do_alloc((i + 2) % 4);
    for (int r = 0; r < 8; r++) begin drv_wr((r + 1) % 8); step(); clr_wr(); end
    drain();

    // Backpressure: at most two reads buffered or in flight
    do_reset();
    resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) do_alloc(3 - i);
    for (int r = 0; r < 4; r++) drv_wr(r);
    step(); clr_wr();
    for (int i = 0; i < 8; i++) @(negedge clk);
    chk("bp_rd_pulses", rd_pulses, 2);
    chk("bp_valid", resp_valid, 1);
    chk("bp_rob", resp_rob, 0);
    for (int i = 0; i < 3; i++) @(negedge clk);
    chk("bp_rob_hold", resp_rob, 0);
    chk("bp_data_hold", resp_data, data_of[0]);
    step();
    resp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_seq_valid", resp_valid, 1);
      chk("bp_seq_rob", resp_rob, k);
    end
    step();
    drain();

    // Protocol errors
    do_reset();
    @(negedge clk); chk("err_init", err, 0);
    step();
    do_alloc(1);
    drv_wr_raw(2, 5, '1); step(); clr_wr();
    @(negedge clk); chk("err_unalloc", err, 1);
    step();
    drv_wr_raw(3, 0, '1); step(); clr_wr();
    @(negedge clk); chk("err_bank", err, 1);
    for (int i = 0; i < 3; i++) @(negedge clk);
    chk("err_no_resp", resp_valid, 0);
    chk("err_no_rd", rd_pulses, 0);
    step();
    drv_wr(0); step(); clr_wr();
    drain();
    @(negedge clk); chk("err_sticky", err, 1);
    step();

    // Reset with a read in flight and one response buffered
    do_reset();
    resp_ready = 1'b0;
    do_alloc(0); do_alloc(1);
    drv_wr(0); drv_wr(1); step(); clr_wr();
    step(); step();
    @(negedge clk); chk("mid_pre_valid", resp_valid, 1);
    sb_en = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb.delete(); tb_tail = 0; rd_pulses = 0;
    @(negedge clk);
    chk("mid_resp_valid", resp_valid, 0);
    chk("mid_rd_en", rd_en, 0);
    chk("mid_alloc_ready", alloc_ready, 1);
    sb_en = 1'b1;
    step();
    do_alloc(2);
    drv_wr(0); step(); clr_wr();
    resp_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cross_bar_rob_ctrl.md
Name: cross_bar_rob_ctrl

Overview:
- Per-channel reorder controller for the channel's four per-bank spw_buffer instances (8 entries each, indexed by rob_num).
- Allocates ROB numbers to outgoing channel requests and records which bank each request targets.
- Tracks bank write-backs into the spw_buffers, then issues in-order reads (rd_en/read_ptr) from the correct bank buffer and presents responses to the channel strictly in allocation order.
- Instantiated alongside the spw_buffers inside the channel's cross_bar_rob.

Parameters:
CHANNEL_ID, 0, channel index; informational, carried to err_ch_o.
DATA_W, 128, response data width; equals spw_buffer data width.

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous active-high reset
alloc_valid_i  input  1  channel requests a ROB entry
alloc_ready_o  output  1  entry available (count < 8)
alloc_bank_i  input  2  target bank of the allocated request
alloc_rob_num_o  output  3  ROB number granted (= tail); valid when alloc_valid_i & alloc_ready_o
bank_wr_valid_i  input  4  per-bank spw_buffer write strobe (bit b = bank b wen)
bank_wr_rob_num_i  input  12  per-bank rob_num, bank b at [3b+2:3b]
bank_rd_en_o  output  4  per-bank spw_buffer rd_en, one-hot or zero
bank_rd_ptr_o  output  3  shared read_ptr to all banks
bank_rd_data_i  input  4*DATA_W  per-bank read_data, bank b at [DATA_W*b +: DATA_W]
resp_valid_o  output  1  in-order response valid
resp_ready_i  input  1  channel accepts response
resp_data_o  output  DATA_W  response data
resp_rob_num_o  output  3  ROB number of the response
err_o  output  1  sticky protocol error
err_ch_o  output  2  CHANNEL_ID[1:0], constant

Behaviour:
- Clock and reset: one clock, clk_i; rst_i synchronous, active-high.
- State:
  - 8 entries {valid, done, bank[1:0]}.
  - head[2:0], tail[2:0], count[3:0].
  - rd_pending flag plus rd_bank[1:0] and rd_rob[2:0].
  - 2-entry output FIFO of {data, rob_num}.
  - err flag.
- Reset:
  - All entries invalid; head = tail = count = 0; rd_pending = 0; FIFO empty; err = 0.
  - Outputs after reset: alloc_ready_o = 1, alloc_rob_num_o = 0, bank_rd_en_o = 0, bank_rd_ptr_o = 0, resp_valid_o = 0, resp_data_o = 0, resp_rob_num_o = 0, err_o = 0.
  - Reset mid-operation discards in-flight reads and FIFO contents. No rd_en is asserted in the reset cycle.
- Allocation:
  - Fire = alloc_valid_i & alloc_ready_o.
  - On fire: entry[tail] <= {1, 0, alloc_bank_i}; tail <= tail + 1 (mod 8).
  - alloc_ready_o is derived from registered count only; no same-cycle bypass from a retire.
- Write tracking:
  - For each bank b with bank_wr_valid_i[b], let r = rob_num of bank b.
  - If entry[r].valid & !entry[r].done & entry[r].bank == b: done <= 1.
  - Otherwise set err (sticky until reset) and leave the entry unchanged.
  - Multiple banks writing different entries in the same cycle are all processed.
  - A write to the entry being allocated in the same cycle is an error, because that entry is not yet valid.
- Read issue:
  - Condition: entry[head].valid & entry[head].done & (fifo_count + rd_pending - pop) < 2, where pop = resp_valid_o & resp_ready_i.
  - Issue cycle outputs: bank_rd_en_o[entry[head].bank] = 1; bank_rd_ptr_o = head.
  - Issue cycle updates: entry[head].valid <= 0; head++; count-- (simultaneous alloc leaves count unchanged); rd_pending <= 1 with bank/rob captured.
- Read return:
  - spw_buffer read latency is 1 cycle.
  - In the cycle after issue, bank_rd_data_i[rd_bank] is pushed into the FIFO with rd_rob; rd_pending clears unless a new issue occurs.
- Response:
  - The FIFO head drives resp_*; resp_valid_o = FIFO non-empty.
  - Data and rob_num are held stable while valid & !ready.
- Latency: bank write in cycle N -> rd_en in N+1 -> data sampled in N+2 -> resp_valid_o in N+3.
- Throughput: 1 response/cycle with resp_ready_i held high.
- Boundaries:
  - Count = 8: alloc_ready_o = 0.
  - Pointers wrap 7 -> 0.
  - Entries completing out of order wait until head is done.
  - resp_ready_i low: at most 2 reads are buffered/in flight; further issues stall.

Test Plan:
- Reset, then alloc 3 requests to banks 0,1,2 -> alloc_rob_num_o = 0,1,2; alloc_ready_o stays 1; count = 3.
- Writes complete in order rob 2 (bank2), rob 0 (bank0), rob 1 (bank1) in cycles 10, 11, 12 with resp_ready_i = 1:
  - bank_rd_en_o = 0001 @12 with ptr 0; 0010 @13 with ptr 1; 0100 @14 with ptr 2.
  - Responses with rob 0, 1, 2 in cycles 14, 15, 16 carry the matching bank data.
- Allocate 8 entries -> alloc_ready_o = 0. Retire one -> alloc_ready_o = 1 the next cycle. Next grant is rob 0 (wrap); tail returns to 0 after 8 more allocations.
- resp_ready_i = 0 with 4 entries done -> exactly 2 rd_en pulses, resp_valid_o = 1 with rob 0 held stable. Raise ready -> rob 0..3 delivered on consecutive cycles.
- Write to unallocated rob 5, or to rob 0 from bank 3 when entry 0 targets bank 1 -> err_o = 1 the next cycle and stays 1; entry states unchanged; normal flow continues.
- Assert rst_i while rd_pending = 1 and the FIFO holds 1 entry -> the next cycle has resp_valid_o = 0, bank_rd_en_o = 0, alloc_ready_o = 1, and the first alloc is granted rob 0.
